// File: rtl/sort_pkg.sv
// Shared definitions for the bitonic sorter and the blocks that feed it.
package sort_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 8;

  typedef logic [DEF_DEPTH-1:0][DEF_WIDTH-1:0] vec_t;

  // Width of an index into n entries, never narrower than one bit.
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sort_arbiter_if.sv
// Bundle of requester, sorter-side and response signals for sort_arbiter.
interface sort_arbiter_if #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 8,
  parameter int NREQ         = 4,
  parameter int MAX_INFLIGHT = 4
);
  import sort_pkg::*;

  localparam int IDW  = id_w(NREQ);
  localparam int CNTW = $clog2(MAX_INFLIGHT) + 1;

  // Requester i transfers in any cycle with req_valid[i] && req_ready[i]. req_ready is
  // combinational from req_valid, so req_valid must never wait on req_ready. Sorter and
  // response sides are strobes with no back-pressure: a valid is consumed the cycle it is high.
  logic [NREQ-1:0]                        req_valid;
  logic [NREQ-1:0]                        req_ready;
  logic [NREQ-1:0][DEPTH-1:0][WIDTH-1:0]  req_data;
  logic                                   hold;

  logic                                   srt_valid_in;
  logic [DEPTH-1:0][WIDTH-1:0]            srt_unsorted;
  logic                                   srt_valid_out;
  logic [DEPTH-1:0][WIDTH-1:0]            srt_sorted;

  logic                                   rsp_valid;
  logic [IDW-1:0]                         rsp_id;
  logic [DEPTH-1:0][WIDTH-1:0]            rsp_data;
  logic [CNTW-1:0]                        inflight;
  logic                                   err_orphan;
  logic [IDW-1:0]                         rr_ptr;

  modport master (
    output req_valid, req_data, hold, srt_valid_out, srt_sorted,
    input  req_ready, srt_valid_in, srt_unsorted, rsp_valid, rsp_id, rsp_data,
           inflight, err_orphan, rr_ptr
  );

  modport slave (
    input  req_valid, req_data, hold, srt_valid_out, srt_sorted,
    output req_ready, srt_valid_in, srt_unsorted, rsp_valid, rsp_id, rsp_data,
           inflight, err_orphan, rr_ptr
  );

endinterface

// File: rtl/sort_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping at NREQ.
module rr_arbiter
  import sort_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic           found;
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      idx = sum[IDW-1:0];
      if (en && !found && req[idx]) begin
        found       = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_id      = idx;
      end
    end
  end

endmodule

// File: rtl/sort_arbiter.sv
// Shares one in-order sorter between NREQ requesters; tags each issued vector with its
// requester ID in a FIFO and returns sorted results with that ID.
module sort_arbiter
  import sort_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 8,
  parameter int NREQ         = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic           clk,
  input  logic           rst,
  sort_arbiter_if.slave  bus
);

  localparam int IDW  = id_w(NREQ);
  localparam int PW   = id_w(MAX_INFLIGHT);
  localparam int CNTW = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [CNTW-1:0] MAX_CNT = CNTW'(MAX_INFLIGHT);
  localparam logic [IDW-1:0]  LAST_ID = IDW'(NREQ - 1);

  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  gnt_id;
  logic [NREQ-1:0] gnt;
  logic            can_issue;
  logic            push;
  logic            pop;

  logic [IDW-1:0]  tag_mem [MAX_INFLIGHT];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CNTW-1:0] inflight;

  // A result leaving the sorter this cycle frees its slot for a same-cycle grant.
  assign can_issue = !rst && !bus.hold && ((inflight < MAX_CNT) || bus.srt_valid_out);
  assign push      = |gnt;
  assign pop       = bus.srt_valid_out && (inflight != '0);

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req    (bus.req_valid),
    .ptr    (rr_ptr),
    .en     (can_issue),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign bus.req_ready = gnt;
  assign bus.inflight  = inflight;
  assign bus.rr_ptr    = rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr           <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      inflight         <= '0;
      bus.srt_valid_in <= 1'b0;
      bus.srt_unsorted <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_id       <= '0;
      bus.rsp_data     <= '0;
      bus.err_orphan   <= 1'b0;
    end else begin
      if (push) begin
        rr_ptr           <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
        wr_ptr           <= wr_ptr + 1'b1;
        bus.srt_unsorted <= bus.req_data[gnt_id];
      end
      bus.srt_valid_in <= push;

      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        bus.rsp_id   <= tag_mem[rd_ptr];
        bus.rsp_data <= bus.srt_sorted;
      end
      bus.rsp_valid <= pop;

      case ({push, pop})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase

      // A sorter result with no outstanding tag cannot be attributed; flag it until reset.
      if (bus.srt_valid_out && (inflight == '0)) bus.err_orphan <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= gnt_id;
  end

  inflight_bound: assert property (@(posedge clk) disable iff (rst) inflight <= MAX_CNT);
  single_grant:   assert property (@(posedge clk) $onehot0(gnt));

endmodule

// File: tb/tb_sort_arbiter.sv
// Directed bench for sort_arbiter with a six-cycle in-order sorter model.
module tb_sort_arbiter;
  import sort_pkg::*;

  localparam int WIDTH        = 32;
  localparam int DEPTH        = 8;
  localparam int NREQ         = 4;
  localparam int MAX_INFLIGHT = 4;
  localparam int L            = 6;
  localparam int DW           = DEPTH * WIDTH;

  logic clk;
  logic rst;
  logic inject;

  int n_tests;
  int n_fail;
  int rsp_seen;
  int lat;

  logic [DW-1:0] exp_q [$];
  logic [1:0]    id_q  [$];
  vec_t          vecs  [NREQ];

  sort_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ), .MAX_INFLIGHT(MAX_INFLIGHT)) bus ();

  sort_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers ----------------
  function automatic vec_t mk(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
    vec_t r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
    return r;
  endfunction

  function automatic vec_t sort_vec(input vec_t v);
    logic [WIDTH-1:0] e [DEPTH];
    logic [WIDTH-1:0] t;
    vec_t r;
    for (int i = 0; i < DEPTH; i++) e[i] = v[i];
    for (int i = 0; i < DEPTH - 1; i++)
      for (int j = 0; j < DEPTH - 1 - i; j++)
        if (e[j] > e[j+1]) begin
          t = e[j]; e[j] = e[j+1]; e[j+1] = t;
        end
    for (int i = 0; i < DEPTH; i++) r[i] = e[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input int id);
    id_q.push_back(2'(id));
    exp_q.push_back(sort_vec(vecs[id]));
  endtask

  task automatic drain(input string tag);
    int lim;
    lim = 0;
    while (bus.inflight != '0 && lim < 40) begin
      tick();
      lim++;
    end
    chk({tag, "_inflight_zero"}, DW'(bus.inflight), DW'(0));
    repeat (2) tick();
    chk({tag, "_all_returned"}, DW'(exp_q.size()), DW'(0));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req_ready"},    DW'(bus.req_ready),    DW'(0));
    chk({tag, "_srt_valid_in"}, DW'(bus.srt_valid_in), DW'(0));
    chk({tag, "_srt_unsorted"}, DW'(bus.srt_unsorted), DW'(0));
    chk({tag, "_rsp_valid"},    DW'(bus.rsp_valid),    DW'(0));
    chk({tag, "_rsp_id"},       DW'(bus.rsp_id),       DW'(0));
    chk({tag, "_rsp_data"},     DW'(bus.rsp_data),     DW'(0));
    chk({tag, "_inflight"},     DW'(bus.inflight),     DW'(0));
    chk({tag, "_err_orphan"},   DW'(bus.err_orphan),   DW'(0));
    chk({tag, "_rr_ptr"},       DW'(bus.rr_ptr),       DW'(0));
  endtask

  // ---------------- sorter model (latency L, shares rst) ----------------
  logic [L-1:0] pv;
  vec_t         pd [L];

  always_ff @(posedge clk) begin
    if (rst) pv <= '0;
    else     pv <= {pv[L-2:0], bus.srt_valid_in};
    pd[0] <= bus.srt_unsorted;
    for (int k = L - 1; k > 0; k--) pd[k] <= pd[k-1];
  end

  assign bus.srt_valid_out = pv[L-1] | inject;
  assign bus.srt_sorted    = sort_vec(pd[L-1]);

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      rsp_seen++;
      n_tests++;
      assert (exp_q.size() != 0)
        else begin
          n_fail++;
          $error("FAIL rsp_unexpected: observed id=%0d expected=no response", bus.rsp_id);
        end
      if (exp_q.size() != 0) begin
        chk("rsp_id",   DW'(bus.rsp_id), DW'(id_q.pop_front()));
        chk("rsp_data", bus.rsp_data,    exp_q.pop_front());
      end
    end
  end

  // ---------------- directed sequence ----------------
  int id_tab [9] = '{0, 1, 2, 3, -1, -1, -1, 0, 1};

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rsp_seen = 0;
    rst      = 1'b1;
    inject   = 1'b0;
    vecs[0] = mk(40, 30, 20, 10, 80, 70, 60, 50);
    vecs[1] = mk(7, 7, 0, 1, 9, 3, 3, 2);
    vecs[2] = mk(10, 3, 25, 7, 1, 18, 2, 5);
    vecs[3] = mk(32'hFFFF_FFFF, 0, 32'h8000_0000, 1, 32'h7FFF_FFFF, 5, 32'hFFFF_FFFE, 4);
    bus.hold      = 1'b0;
    bus.req_valid = '1;
    for (int i = 0; i < NREQ; i++) bus.req_data[i] = vecs[i];

    // Reset holds everything idle even with all requesters valid.
    repeat (3) tick();
    chk_reset_values("reset");

    // Single request from requester 2.
    rst           = 1'b0;
    bus.req_valid = 4'b0100;
    #1;
    chk("t1_req_ready", DW'(bus.req_ready), DW'(4'b0100));
    id_q.push_back(2'd2);
    exp_q.push_back(mk(1, 2, 3, 5, 7, 10, 18, 25));
    tick();
    bus.req_valid = '0;
    chk("t1_srt_valid_in", DW'(bus.srt_valid_in), DW'(1));
    chk("t1_srt_unsorted", bus.srt_unsorted, vecs[2]);
    chk("t1_inflight",     DW'(bus.inflight),  DW'(1));
    chk("t1_rr_ptr",       DW'(bus.rr_ptr),    DW'(3));
    tick();
    chk("t1_valid_in_drop", DW'(bus.srt_valid_in), DW'(0));
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk("t1_latency",     DW'(lat),          DW'(L + 1));
    chk("t1_inflight_end", DW'(bus.inflight), DW'(0));
    tick();

    // Fairness and saturation: all valid from reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t2_rr_ptr_rst", DW'(bus.rr_ptr), DW'(0));
    bus.req_valid = '1;
    for (int c = 0; c < 9; c++) begin
      logic [3:0] rdy;
      rdy = (id_tab[c] < 0) ? 4'b0000 : (4'b0001 << id_tab[c]);
      #1;
      chk($sformatf("t2_req_ready_c%0d", c), DW'(bus.req_ready), DW'(rdy));
      if (id_tab[c] >= 0) push_exp(id_tab[c]);
      tick();
      if (c == 3 || c == 7 || c == 8)
        chk($sformatf("t2_inflight_c%0d", c), DW'(bus.inflight), DW'(MAX_INFLIGHT));
    end
    bus.req_valid = '0;
    drain("t2");

    // Hold after two grants; rr_ptr is 2 here.
    bus.req_valid = '1;
    #1;
    chk("t3_req_ready_a", DW'(bus.req_ready), DW'(4'b0100));
    push_exp(2);
    tick();
    #1;
    chk("t3_req_ready_b", DW'(bus.req_ready), DW'(4'b1000));
    push_exp(3);
    tick();
    bus.hold = 1'b1;
    #1;
    chk("t3_inflight", DW'(bus.inflight), DW'(2));
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("t3_hold_ready_c%0d", c), DW'(bus.req_ready), DW'(0));
      tick();
    end
    chk("t3_inflight_end", DW'(bus.inflight), DW'(0));
    chk("t3_returned",     DW'(exp_q.size()), DW'(0));
    bus.hold      = 1'b0;
    bus.req_valid = '0;

    // Orphan result with nothing outstanding.
    chk("t4_err_before", DW'(bus.err_orphan), DW'(0));
    inject = 1'b1;
    tick();
    inject = 1'b0;
    chk("t4_err_set",     DW'(bus.err_orphan), DW'(1));
    chk("t4_rsp_valid_a", DW'(bus.rsp_valid),  DW'(0));
    chk("t4_inflight",    DW'(bus.inflight),   DW'(0));
    tick();
    chk("t4_rsp_valid_b", DW'(bus.rsp_valid),  DW'(0));
    repeat (3) tick();
    chk("t4_err_sticky",  DW'(bus.err_orphan), DW'(1));

    // Reset with three vectors in flight; their tags are discarded.
    bus.req_valid = '1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("t5_req_ready_c%0d", c), DW'(bus.req_ready), DW'(4'b0001 << c));
      tick();
    end
    chk("t5_inflight", DW'(bus.inflight), DW'(3));
    bus.req_valid = '0;
    rst           = 1'b1;
    tick();
    chk_reset_values("t5_after_rst");
    rst = 1'b0;
    repeat (15) tick();
    chk("t5_no_stale_rsp", DW'(rsp_seen),     DW'(9));
    chk("t5_inflight_end", DW'(bus.inflight), DW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
